// File: rtl/riscv_pkg.sv
// Shared RISC-V instruction types: opcode map, encoder format codes and
// immediate limits used by the field-to-instruction encoder.
package riscv_pkg;

    typedef logic [31:0] instruction_t;

    typedef enum logic [6:0] {
        OP_LOAD      = 7'h03,
        OP_MISC_MEM  = 7'h0F,
        OP_IMM       = 7'h13,
        OP_AUIPC     = 7'h17,
        OP_IMM_32    = 7'h1B,
        OP_STORE     = 7'h23,
        OP_OP        = 7'h33,
        OP_LUI       = 7'h37,
        OP_OP_32     = 7'h3B,
        OP_BRANCH    = 7'h63,
        OP_JALR      = 7'h67,
        OP_JAL       = 7'h6F,
        OP_SYSTEM    = 7'h73
    } op_inst_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_fmt_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    // One buffered result: error flag alongside the (zeroed on error) word.
    typedef struct packed {
        logic         err;
        instruction_t inst;
    } enc_entry_t;

endpackage

// File: rtl/riscv_inst_fifo.sv
// Small synchronous FIFO with flush; head data reads as zero while empty.
module riscv_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] wptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot being written, so push-while-full is legal then.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem[rptr_q];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/riscv_inst_encoder.sv
// Packs decoded RISC-V fields into a 32-bit instruction, range-checks the
// immediate, and buffers results through a stage register and output FIFO.
module riscv_inst_encoder
    import riscv_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           req_fmt_i,
    input  logic [6:0]           req_opcode_i,
    input  logic [2:0]           req_func3_i,
    input  logic [6:0]           req_func7_i,
    input  logic [4:0]           req_rd_i,
    input  logic [4:0]           req_rs1_i,
    input  logic [4:0]           req_rs2_i,
    input  logic [31:0]          req_imm_i,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic [31:0]          inst_o,
    output logic                 inst_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    function automatic logic imm_in_range(input logic signed [31:0] v,
                                          input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic enc_entry_t encode(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [2:0]  func3,
        input logic [6:0]  func7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_entry_t          res;
        instruction_t        inst;
        logic                ok;
        logic signed [31:0]  simm;
        simm = $signed(imm);
        inst = '0;
        ok   = 1'b0;
        case (inst_fmt_t'(fmt))
            FMT_R: begin
                ok   = 1'b1;
                inst = {func7, rs2, rs1, func3, rd, opcode};
            end
            FMT_I: begin
                ok   = imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
                inst = {imm[11:0], rs1, func3, rd, opcode};
            end
            FMT_S: begin
                ok   = imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
                inst = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            end
            FMT_B: begin
                ok   = imm_in_range(simm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
                inst = {imm[12], imm[10:5], rs2, rs1, func3,
                        imm[4:1], imm[11], opcode};
            end
            FMT_U: begin
                ok   = (imm[11:0] == 12'h000);
                inst = {imm[31:12], rd, opcode};
            end
            FMT_J: begin
                ok   = imm_in_range(simm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: begin
                ok   = 1'b0;
                inst = '0;
            end
        endcase
        res.err  = !ok;
        res.inst = ok ? inst : '0;
        return res;
    endfunction

    enc_entry_t           enc_res;
    enc_entry_t           s1_entry_q;
    logic                 s1_valid_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    enc_entry_t           fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 req_fire;
    logic                 s1_drain;

    always_comb begin
        enc_res = encode(req_fmt_i, req_opcode_i, req_func3_i, req_func7_i,
                         req_rd_i, req_rs1_i, req_rs2_i, req_imm_i);
    end

    // Ready looks only at registered state so inst_ready_i never reaches it.
    assign req_ready_o = !s1_valid_q || !fifo_full;
    assign req_fire    = req_valid_i && req_ready_o && !flush_i;
    assign s1_drain    = s1_valid_q && !fifo_full;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (req_fire) begin
            s1_valid_q <= 1'b1;
            s1_entry_q <= enc_res;
        end else if (s1_drain) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Survives flush on purpose: it tracks encode faults since reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt_q <= '0;
        end else if (req_fire && enc_res.err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    riscv_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(enc_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (flush_i),
        .push_i  (s1_drain),
        .wdata_i (s1_entry_q),
        .pop_i   (inst_ready_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_head.inst;
    assign inst_err_o   = fifo_head.err;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Scoreboard bench for riscv_inst_encoder: driver pushes expected entries,
// an independent monitor pops and compares on every response transfer.
module tb_riscv_inst_encoder;
    import riscv_pkg::*;

    localparam int DEPTH = 2;
    localparam int ECW   = 8;

    typedef logic [32:0] ent_t;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic           flush_i = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [2:0]     req_fmt_i = '0;
    logic [6:0]     req_opcode_i = '0;
    logic [2:0]     req_func3_i = '0;
    logic [6:0]     req_func7_i = '0;
    logic [4:0]     req_rd_i = '0;
    logic [4:0]     req_rs1_i = '0;
    logic [4:0]     req_rs2_i = '0;
    logic [31:0]    req_imm_i = '0;
    logic           inst_valid_o;
    logic           inst_ready_i = 1'b0;
    logic [31:0]    inst_o;
    logic           inst_err_o;
    logic [ECW-1:0] err_cnt_o;

    riscv_inst_encoder #(.DEPTH(DEPTH), .ERR_CNT_W(ECW)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_fmt_i    (req_fmt_i),
        .req_opcode_i (req_opcode_i),
        .req_func3_i  (req_func3_i),
        .req_func7_i  (req_func7_i),
        .req_rd_i     (req_rd_i),
        .req_rs1_i    (req_rs1_i),
        .req_rs2_i    (req_rs2_i),
        .req_imm_i    (req_imm_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_err_o   (inst_err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_vec = 0;
    int     n_bad = 0;
    longint cyc = 0;
    ent_t   exp_q[$];
    longint pop_t[$];
    int     m_cnt = 0;
    bit     rand_rdy = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding from the format tables, using integer arithmetic.
    function automatic ent_t ref_enc(input int fmt, input int op, input int f3,
                                     input int f7, input int rd, input int rs1,
                                     input int rs2, input int imm);
        longint v;
        longint base;
        longint r;
        bit     ok;
        v    = imm;
        base = (longint'(rs1) << 15) | (longint'(f3) << 12) | longint'(op);
        r    = 0;
        ok   = 1'b0;
        case (fmt)
            0: begin
                ok = 1'b1;
                r  = base | (longint'(f7) << 25) | (longint'(rs2) << 20) | (longint'(rd) << 7);
            end
            1: begin
                ok = (v >= -2048) && (v <= 2047);
                r  = base | ((v & 'hFFF) << 20) | (longint'(rd) << 7);
            end
            2: begin
                ok = (v >= -2048) && (v <= 2047);
                r  = base | (((v >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | ((v & 'h1F) << 7);
            end
            3: begin
                ok = (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
                r  = base | (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25)
                   | (longint'(rs2) << 20) | (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7);
            end
            4: begin
                ok = ((v & 'hFFF) == 0);
                r  = (v & 'hFFFFF000) | (longint'(rd) << 7) | longint'(op);
            end
            5: begin
                ok = (v >= -(64'sd1 << 20)) && (v <= (64'sd1 << 20) - 2) && ((v & 1) == 0);
                r  = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20)
                   | (((v >> 12) & 'hFF) << 12) | (longint'(rd) << 7) | longint'(op);
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, r[31:0]} : {1'b1, 32'h0};
    endfunction

    task automatic send(input int fmt, input int op, input int f3, input int f7,
                        input int rd, input int rs1, input int rs2, input int imm,
                        input ent_t exp, input int max_cyc, output bit acc);
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_fmt_i    = 3'(fmt);
        req_opcode_i = 7'(op);
        req_func3_i  = 3'(f3);
        req_func7_i  = 7'(f7);
        req_rd_i     = 5'(rd);
        req_rs1_i    = 5'(rs1);
        req_rs2_i    = 5'(rs2);
        req_imm_i    = imm;
        #1;
        acc = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
            if (i + 1 < max_cyc) begin
                @(negedge clk_i);
                #1;
            end
        end
        if (!acc) req_valid_i = 1'b0;
        if (acc && !flush_i) begin
            exp_q.push_back(exp);
            if (exp[32] && m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic send_ok(input int fmt, input int op, input int f3, input int f7,
                           input int rd, input int rs1, input int rs2, input int imm,
                           input ent_t exp);
        bit acc;
        send(fmt, op, f3, f7, rd, rs1, rs2, imm, exp, 60, acc);
        if (!acc) chk("req_accept_timeout", longint'(acc), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        inst_ready_i = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        #1;
        chk("drain_queue_empty", longint'(exp_q.size()), 0);
        chk("drain_no_valid", longint'(inst_valid_o), 0);
    endtask

    ent_t prev_ent;
    bit   prev_stall = 1'b0;

    always @(negedge clk_i) begin
        ent_t e;
        #2;
        if (!rstn_i || flush_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && inst_valid_o)
                chk("stall_stable", longint'({inst_err_o, inst_o}), longint'(prev_ent));
            if (!inst_valid_o)
                chk("empty_zero", longint'({inst_err_o, inst_o}), 0);
            if (inst_valid_o && inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%0h, expected nothing", {inst_err_o, inst_o});
                end else begin
                    e = exp_q.pop_front();
                    chk("inst", longint'(inst_o), longint'(e[31:0]));
                    chk("err", longint'(inst_err_o), longint'(e[32]));
                    pop_t.push_back(cyc);
                end
            end
            prev_stall = inst_valid_o && !inst_ready_i;
            prev_ent   = {inst_err_o, inst_o};
        end
    end

    always @(negedge clk_i) begin
        if (rand_rdy) inst_ready_i = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                    -4098, -4097, 1048574, 1048576, -1048576, -1048578,
                    32'h12345000, 32'h12345001};

    initial begin
        int  fmt, op, f3, f7, rd, rs1, rs2, imm, acc_n, sz;
        bit  acc;

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_req_ready", longint'(req_ready_o), 1);
        chk("rst_inst_valid", longint'(inst_valid_o), 0);
        chk("rst_inst", longint'(inst_o), 0);
        chk("rst_inst_err", longint'(inst_err_o), 0);
        chk("rst_err_cnt", longint'(err_cnt_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        inst_ready_i = 1'b1;

        // ADDI x1,x0,5 and its two-cycle latency
        send_ok(1, 'h13, 0, 0, 1, 0, 0, 5, 33'h0_00500093);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        chk("lat_s1_not_visible", longint'(inst_valid_o), 0);
        @(negedge clk_i);
        #1;
        chk("lat_head_valid", longint'(inst_valid_o), 1);
        drain();

        // ADD x3,x1,x2 then LUI x5,0x12345000 back to back
        send_ok(0, 'h33, 0, 0, 3, 1, 2, 0, 33'h0_002081B3);
        send_ok(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000, 33'h0_123452B7);
        drain();
        sz = pop_t.size();
        chk("b2b_consecutive", pop_t[sz-1] - pop_t[sz-2], 1);

        send_ok(3, 'h63, 0, 0, 0, 1, 2, 8, 33'h0_00208463);
        send_ok(5, 'h6F, 0, 0, 1, 0, 0, 16, 33'h0_010000EF);
        drain();

        send_ok(1, 'h13, 0, 0, 1, 0, 0, 2048, 33'h1_00000000);
        drain();
        chk("err_cnt_first", longint'(err_cnt_o), 1);
        send_ok(3, 'h63, 0, 0, 0, 1, 2, 3, 33'h1_00000000);
        drain();
        chk("err_cnt_second", longint'(err_cnt_o), longint'(m_cnt));

        // randomized fields with random consumer backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            fmt = $urandom_range(0, 7);
            op  = $urandom_range(0, 127);
            f3  = $urandom_range(0, 7);
            f7  = $urandom_range(0, 127);
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = int'($urandom_range(0, 10000)) - 5000;
                2:       imm = bnd[$urandom_range(0, 15)];
                default: imm = int'($urandom_range(0, 2047)) * 2 - 2048;
            endcase
            send_ok(fmt, op, f3, f7, rd, rs1, rs2, imm,
                    ref_enc(fmt, op, f3, f7, rd, rs1, rs2, imm));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rand_rdy = 1'b0;
        drain();
        chk("err_cnt_random", longint'(err_cnt_o), longint'(m_cnt));

        // counter saturation with undefined format codes
        for (int n = 0; n < 260; n++)
            send_ok(6 + (n % 2), 'h13, 0, 0, 1, 1, 1, 0, 33'h1_00000000);
        drain();
        chk("err_cnt_saturated", longint'(err_cnt_o), 255);

        // backpressure: only S1 plus DEPTH entries fit
        inst_ready_i = 1'b0;
        acc_n = 0;
        for (int n = 0; n < 4; n++) begin
            send(0, 'h33, n, 0, n + 1, n + 2, n + 3, 0,
                 ref_enc(0, 'h33, n, 0, n + 1, n + 2, n + 3, 0), 1, acc);
            acc_n += int'(acc);
        end
        idle(3);
        #1;
        chk("bp_accepted", longint'(acc_n), 3);
        chk("bp_req_ready_low", longint'(req_ready_o), 0);
        chk("bp_inst_valid", longint'(inst_valid_o), 1);
        drain();

        // flush with the FIFO full and a concurrent erroring request
        inst_ready_i = 1'b0;
        send_ok(0, 'h33, 1, 0, 7, 8, 9, 0, ref_enc(0, 'h33, 1, 0, 7, 8, 9, 0));
        send_ok(0, 'h33, 2, 0, 10, 11, 12, 0, ref_enc(0, 'h33, 2, 0, 10, 11, 12, 0));
        idle(3);
        #1;
        chk("flush_pre_valid", longint'(inst_valid_o), 1);
        chk("flush_pre_ready", longint'(req_ready_o), 1);
        @(negedge clk_i);
        flush_i      = 1'b1;
        req_valid_i  = 1'b1;
        req_fmt_i    = 3'd7;
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        #1;
        exp_q.delete();
        chk("flush_valid_low", longint'(inst_valid_o), 0);
        chk("flush_err_cnt", longint'(err_cnt_o), longint'(m_cnt));
        idle(3);
        #1;
        chk("flush_req_dropped", longint'(inst_valid_o), 0);
        chk("flush_ready_high", longint'(req_ready_o), 1);
        inst_ready_i = 1'b1;
        send_ok(1, 'h13, 0, 0, 1, 0, 0, 5, 33'h0_00500093);
        drain();

        // reset mid-stream drops buffered entries and the counter
        inst_ready_i = 1'b0;
        send_ok(0, 'h33, 0, 0, 3, 1, 2, 0, 33'h0_002081B3);
        send_ok(0, 'h33, 0, 0, 3, 1, 2, 0, 33'h0_002081B3);
        idle(2);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        exp_q.delete();
        m_cnt = 0;
        chk("midrst_valid", longint'(inst_valid_o), 0);
        chk("midrst_err_cnt", longint'(err_cnt_o), 0);
        chk("midrst_ready", longint'(req_ready_o), 1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        inst_ready_i = 1'b1;
        send_ok(5, 'h6F, 0, 0, 1, 0, 0, 16, 33'h0_010000EF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
